ff_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one external 32-bit enable/clear pipeline register between N_REQ producers in the bcrypt datapath.
- Drives the register's en, rst and data inputs, and tracks whether the register is occupied.
- Hands the held word to a single consumer over a valid/read handshake, tagged with the index of its source.

---
 rtl/ff_share_arb_if.sv | 29 ++
 rtl/ff_share_arb.sv | 70 +++++++
 tb/tb_ff_share_arb.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ff_share_arb_if.sv
// Bundle of requester, shared-register and consumer signals around ff_share_arb.
// master = requesters/consumer/register side, slave = the arbiter.
interface ff_share_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] din;
  logic [N_REQ-1:0]   gnt;
  logic               clear;
  logic               ff_en;
  logic               ff_rst;
  logic [W-1:0]       ff_d;
  logic               out_valid;
  logic               out_rd;
  logic [ID_W-1:0]    src_id;
  logic               busy;

  modport master (
    output req, din, clear, out_rd,
    input  gnt, ff_en, ff_rst, ff_d, out_valid, src_id, busy
  );

  modport slave (
    input  req, din, clear, out_rd,
    output gnt, ff_en, ff_rst, ff_d, out_valid, src_id, busy
  );
endinterface

// File: rtl/ff_share_arb.sv
// Round-robin arbiter sharing one external enable/clear pipeline register
// between N_REQ producers; tracks occupancy and tags the held word with its source.
module ff_share_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned ID_W  = 2
) (
  input logic          CLK,
  input logic          rst,
  ff_share_arb_if.slave bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   src_id_q;
  logic [PTR_W-1:0]  ptr_q;

  logic              slot_free;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  cand;
  logic              grant_ok;

  // Wrap-around search for the first request at or after ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % N_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign slot_free = (state_q == EMPTY) | bus.out_rd;
  assign grant_ok  = slot_free & ~bus.clear & win_found & ~rst;

  assign bus.gnt       = grant_ok ? (N_REQ'(1) << win_idx) : '0;
  assign bus.ff_en     = grant_ok;
  assign bus.ff_rst    = bus.clear & ~rst;
  assign bus.ff_d      = grant_ok ? bus.din[32'(win_idx)*W +: W] : '0;
  assign bus.out_valid = (state_q == FULL);
  assign bus.src_id    = src_id_q;
  assign bus.busy      = (state_q == FULL) | (|bus.req);

  // Occupancy, source tag and round-robin pointer; clear outranks grant and consume.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      src_id_q <= '0;
      ptr_q    <= '0;
    end else if (bus.clear) begin
      state_q  <= EMPTY;
      src_id_q <= '0;
    end else if (grant_ok) begin
      state_q  <= FULL;
      src_id_q <= ID_W'(win_idx);
      ptr_q    <= (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + PTR_W'(1);
    end else if (state_q == FULL && bus.out_rd) begin
      state_q  <= EMPTY;
    end
  end

endmodule

// File: tb/tb_ff_share_arb.sv
// Directed self-checking bench for ff_share_arb (N_REQ=4, W=32, ID_W=2).
module tb_ff_share_arb;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [31:0] din_v [4];
  logic [3:0]  e_gnt;

  ff_share_arb_if #(.N_REQ(4), .W(32), .ID_W(2)) bus ();

  ff_share_arb #(.N_REQ(4), .W(32), .ID_W(2)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.req = '0; bus.clear = 1'b0; bus.out_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.clear = 1'b1; bus.out_rd = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    n_cmp++; if (bus.src_id !== 2'd0) begin n_bad++; $display("FAIL rst_src_id got %0d exp 0", bus.src_id); end
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt got %b exp 0000", bus.gnt); end
    n_cmp++; if (bus.ff_en !== 1'b0) begin n_bad++; $display("FAIL rst_ff_en got %b exp 0", bus.ff_en); end
    n_cmp++; if (bus.ff_rst !== 1'b0) begin n_bad++; $display("FAIL rst_ff_rst got %b exp 0", bus.ff_rst); end
    n_cmp++; if (dut.ptr_q !== 2'd0) begin n_bad++; $display("FAIL rst_ptr got %0d exp 0", dut.ptr_q); end
    bus.clear = 1'b0; bus.out_rd = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_single_grant();
    apply_reset();
    bus.req = 4'b0010; bus.out_rd = 1'b0; #1;
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL single_gnt got %b exp 0010", bus.gnt); end
    n_cmp++; if (bus.ff_en !== 1'b1) begin n_bad++; $display("FAIL single_ff_en got %b exp 1", bus.ff_en); end
    n_cmp++; if (bus.ff_d !== 32'hA5A5_0001) begin n_bad++; $display("FAIL single_ff_d got %h exp a5a50001", bus.ff_d); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b exp 1", bus.busy); end
    @(negedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
    n_cmp++; if (bus.src_id !== 2'd1) begin n_bad++; $display("FAIL single_src got %0d exp 1", bus.src_id); end
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL single_full_gnt got %b exp 0000", bus.gnt); end
    n_cmp++; if (bus.ff_d !== 32'h0) begin n_bad++; $display("FAIL single_ff_d_idle got %h exp 0", bus.ff_d); end
    n_cmp++; if (dut.ptr_q !== 2'd2) begin n_bad++; $display("FAIL single_ptr got %0d exp 2", dut.ptr_q); end
    bus.req = 4'b0000; bus.out_rd = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_consume got %b exp 0", bus.out_valid); end
    bus.out_rd = 1'b0;
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      bus.req = 4'b1111; bus.out_rd = 1'b1; #1;
      e_gnt = 4'b0001 << (c % 4);
      n_cmp++; if (bus.gnt !== e_gnt) begin n_bad++; $display("FAIL rr_gnt[%0d] got %b exp %b", c, bus.gnt, e_gnt); end
      n_cmp++; if (bus.ff_d !== din_v[c % 4]) begin n_bad++; $display("FAIL rr_ff_d[%0d] got %h exp %h", c, bus.ff_d, din_v[c % 4]); end
      if (c > 0) begin
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid[%0d] got %b exp 1", c, bus.out_valid); end
        n_cmp++; if (bus.src_id !== 2'((c - 1) % 4)) begin n_bad++; $display("FAIL rr_src[%0d] got %0d exp %0d", c, bus.src_id, (c - 1) % 4); end
      end
      @(negedge clk);
    end
    bus.req = 4'b0000; #1;
    n_cmp++; if (bus.src_id !== 2'd0) begin n_bad++; $display("FAIL rr_last_src got %0d exp 0", bus.src_id); end
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL rr_drain_gnt got %b exp 0000", bus.gnt); end
    @(negedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drain_valid got %b exp 0", bus.out_valid); end
    bus.out_rd = 1'b0;
  endtask

  task automatic test_wraparound();
    apply_reset();
    bus.req = 4'b0100; bus.out_rd = 1'b1; #1;
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL wrap_setup_gnt got %b exp 0100", bus.gnt); end
    @(negedge clk);
    bus.req = 4'b1001; #1;
    n_cmp++; if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_gnt3 got %b exp 1000", bus.gnt); end
    n_cmp++; if (bus.ff_d !== din_v[3]) begin n_bad++; $display("FAIL wrap_ff_d3 got %h exp %h", bus.ff_d, din_v[3]); end
    @(negedge clk); #1;
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt0 got %b exp 0001", bus.gnt); end
    n_cmp++; if (bus.src_id !== 2'd3) begin n_bad++; $display("FAIL wrap_src got %0d exp 3", bus.src_id); end
    @(negedge clk);
    bus.req = 4'b0000;
    @(negedge clk);
    bus.out_rd = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.req = 4'b0001; bus.out_rd = 1'b0; #1;
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL bp_setup_gnt got %b exp 0001", bus.gnt); end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      bus.req = 4'b0100; bus.out_rd = 1'b0; #1;
      n_cmp++; if (bus.gnt !== 4'b0000 || bus.ff_en !== 1'b0) begin n_bad++; $display("FAIL bp_hold[%0d] got gnt=%b en=%b exp 0000/0", c, bus.gnt, bus.ff_en); end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b exp 1", c, bus.out_valid); end
      @(negedge clk);
    end
    bus.out_rd = 1'b1; #1;
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL bp_release_gnt got %b exp 0100", bus.gnt); end
    n_cmp++; if (bus.ff_d !== din_v[2]) begin n_bad++; $display("FAIL bp_release_ff_d got %h exp %h", bus.ff_d, din_v[2]); end
    @(negedge clk);
    bus.req = 4'b0000; bus.out_rd = 1'b0; #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.src_id !== 2'd2) begin n_bad++; $display("FAIL bp_after got v=%b src=%0d exp 1/2", bus.out_valid, bus.src_id); end
  endtask

  task automatic test_clear();
    apply_reset();
    bus.req = 4'b0010; bus.out_rd = 1'b0;
    @(negedge clk);
    bus.req = 4'b0001; bus.out_rd = 1'b1; bus.clear = 1'b1; #1;
    n_cmp++; if (bus.ff_rst !== 1'b1) begin n_bad++; $display("FAIL clr_ff_rst got %b exp 1", bus.ff_rst); end
    n_cmp++; if (bus.gnt !== 4'b0000 || bus.ff_en !== 1'b0) begin n_bad++; $display("FAIL clr_gnt got gnt=%b en=%b exp 0000/0", bus.gnt, bus.ff_en); end
    @(negedge clk);
    bus.clear = 1'b0; bus.out_rd = 1'b0; #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid got %b exp 0", bus.out_valid); end
    n_cmp++; if (bus.src_id !== 2'd0) begin n_bad++; $display("FAIL clr_src got %0d exp 0", bus.src_id); end
    n_cmp++; if (dut.ptr_q !== 2'd2) begin n_bad++; $display("FAIL clr_ptr got %0d exp 2", dut.ptr_q); end
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL clr_next_gnt got %b exp 0001", bus.gnt); end
    n_cmp++; if (bus.ff_rst !== 1'b0) begin n_bad++; $display("FAIL clr_ff_rst_off got %b exp 0", bus.ff_rst); end
    @(negedge clk);
    bus.req = 4'b0000;
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.req = 4'b0001; bus.out_rd = 1'b0;
    @(negedge clk);
    bus.req = 4'b0010; #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_full got %b exp 1", bus.out_valid); end
    rst = 1'b1; #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got %b exp 0", bus.out_valid); end
    n_cmp++; if (bus.gnt !== 4'b0000 || bus.ff_en !== 1'b0) begin n_bad++; $display("FAIL ar_gnt got gnt=%b en=%b exp 0000/0", bus.gnt, bus.ff_en); end
    @(negedge clk);
    rst = 1'b0; bus.req = 4'b0011; #1;
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL ar_ptr_gnt got %b exp 0001", bus.gnt); end
    n_cmp++; if (dut.ptr_q !== 2'd0) begin n_bad++; $display("FAIL ar_ptr got %0d exp 0", dut.ptr_q); end
    @(negedge clk);
    bus.req = 4'b0000;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int k = 0; k < 4; k++) din_v[k] = 32'hA5A5_0000 | 32'(k);
    din_v[0] = 32'h1234_5678;
    for (int k = 0; k < 4; k++) bus.din[k*32 +: 32] = din_v[k];
    rst = 1'b1; bus.req = '0; bus.clear = 1'b0; bus.out_rd = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_grant();
    test_round_robin();
    test_wraparound();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
